// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction codes, FSM states and helpers for the snake body engine.
package snake_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_DOWN  = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  localparam int PEND_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD
  } state_t;

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      DIR_DOWN:  opposite = DIR_UP;
      DIR_UP:    opposite = DIR_DOWN;
      DIR_RIGHT: opposite = DIR_LEFT;
      DIR_LEFT:  opposite = DIR_RIGHT;
      default:   opposite = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/snake_body_engine_if.sv
// rtl/snake_body_engine_if.sv - direction/grow inputs and body/status outputs of the snake engine.
interface snake_body_engine_if #(
  parameter int MAX_LEN = 128,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic [3:0]             dir;
  logic                   grow;
  logic [MAX_LEN*X_W-1:0] snake_x;
  logic [MAX_LEN*Y_W-1:0] snake_y;
  logic [LEN_W-1:0]       length;
  logic                   running;
  logic                   dead;

  modport master (
    output dir, grow,
    input  snake_x, snake_y, length, running, dead
  );

  modport slave (
    input  dir, grow,
    output snake_x, snake_y, length, running, dead
  );
endinterface

// File: rtl/snake_collision_check.sv
// rtl/snake_collision_check.sv - flags a new head landing on any body segment below i_limit.
module snake_collision_check #(
  parameter int MAX_LEN = 128,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [X_W-1:0]         i_new_x,
  input  logic [Y_W-1:0]         i_new_y,
  input  logic [MAX_LEN*X_W-1:0] i_seg_x,
  input  logic [MAX_LEN*Y_W-1:0] i_seg_y,
  input  logic [LEN_W-1:0]       i_limit,
  output logic                   o_hit
);

  // Segment 0 is the current head, which the new head can never coincide with.
  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i != 0) && (LEN_W'(i) < i_limit) &&
          (i_seg_x[i*X_W +: X_W] == i_new_x) &&
          (i_seg_y[i*Y_W +: Y_W] == i_new_y)) begin
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_body_engine.sv
// rtl/snake_body_engine.sv - snake body shift register, heading, growth and collision FSM.
// SNAKE_WRAP_EN: head wraps at the field edges instead of dying on the wall.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 128,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int SEG_W     = 10,
  parameter int SEG_H     = 10,
  parameter int FIELD_W   = 640,
  parameter int FIELD_H   = 480,
  parameter int START_X   = 100,
  parameter int START_Y   = 160,
  parameter int GROW_STEP = 2,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input logic                screenClock,
  input logic                reset,
  snake_body_engine_if.slave bus
);

  localparam logic [X_W:0]    STEP_X   = (X_W+1)'(SEG_W);
  localparam logic [Y_W:0]    STEP_Y   = (Y_W+1)'(SEG_H);
  localparam logic [X_W:0]    X_MAX    = (X_W+1)'(FIELD_W - SEG_W);
  localparam logic [Y_W:0]    Y_MAX    = (Y_W+1)'(FIELD_H - SEG_H);
  localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

  logic [X_W-1:0]    r_seg_x [MAX_LEN];
  logic [Y_W-1:0]    r_seg_y [MAX_LEN];
  logic [LEN_W-1:0]  r_length;
  logic [PEND_W-1:0] r_pending;
  logic [3:0]        r_heading;
  state_t            r_state;
  logic              r_running;
  logic              r_dead;

  logic [MAX_LEN*X_W-1:0] w_flat_x;
  logic [MAX_LEN*Y_W-1:0] w_flat_y;
  logic                   w_dir_valid;
  logic                   w_reversal;
  logic [3:0]             w_heading_next;
  logic                   w_move_req;
  logic [X_W:0]           w_x_ext;
  logic [Y_W:0]           w_y_ext;
  logic [X_W-1:0]         w_new_x;
  logic [Y_W-1:0]         w_new_y;
  logic                   w_wall;
  logic                   w_hit;
  logic                   w_collide;
  logic                   w_do_move;
  logic                   w_will_grow;
  logic [LEN_W-1:0]       w_length_next;
  logic [LEN_W-1:0]       w_limit;
  logic [PEND_W:0]        w_pend_sum;
  logic [PEND_W-1:0]      w_pending_next;

  always_comb begin
    w_flat_x = '0;
    w_flat_y = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_flat_x[i*X_W +: X_W] = r_seg_x[i];
      w_flat_y[i*Y_W +: Y_W] = r_seg_y[i];
    end
  end

  assign bus.snake_x = w_flat_x;
  assign bus.snake_y = w_flat_y;
  assign bus.length  = r_length;
  assign bus.running = r_running;
  assign bus.dead    = r_dead;

  // A single-segment snake may reverse freely; a longer one would bite its neck.
  assign w_dir_valid    = $onehot(bus.dir);
  assign w_reversal     = (bus.dir == opposite(r_heading)) && (r_length > LEN_W'(1));
  assign w_heading_next = (w_dir_valid && !w_reversal) ? bus.dir : r_heading;
  assign w_move_req     = (r_state == ST_RUN) || ((r_state == ST_IDLE) && w_dir_valid);

  always_comb begin
    w_x_ext = {1'b0, r_seg_x[0]};
    w_y_ext = {1'b0, r_seg_y[0]};
    case (w_heading_next)
      DIR_RIGHT: w_x_ext = w_x_ext + STEP_X;
      DIR_LEFT:  w_x_ext = w_x_ext - STEP_X;
      DIR_DOWN:  w_y_ext = w_y_ext + STEP_Y;
      DIR_UP:    w_y_ext = w_y_ext - STEP_Y;
      default:   ;
    endcase
  end

  // The extra MSB catches underflow; anything past the last legal cell is off-field.
  always_comb begin
`ifdef SNAKE_WRAP_EN
    if (w_x_ext[X_W])        w_new_x = X_MAX[X_W-1:0];
    else if (w_x_ext > X_MAX) w_new_x = '0;
    else                      w_new_x = w_x_ext[X_W-1:0];
    if (w_y_ext[Y_W])        w_new_y = Y_MAX[Y_W-1:0];
    else if (w_y_ext > Y_MAX) w_new_y = '0;
    else                      w_new_y = w_y_ext[Y_W-1:0];
    w_wall = 1'b0;
`else
    w_new_x = w_x_ext[X_W-1:0];
    w_new_y = w_y_ext[Y_W-1:0];
    w_wall  = (w_x_ext > X_MAX) || (w_y_ext > Y_MAX);
`endif
  end

  // The tail cell is vacated this move unless the snake grows into it.
  assign w_will_grow   = (r_pending != '0) && (r_length < LEN_W'(MAX_LEN));
  assign w_length_next = w_will_grow ? r_length + LEN_W'(1) : r_length;
  assign w_limit       = w_will_grow ? r_length : r_length - LEN_W'(1);

  snake_collision_check #(
    .MAX_LEN (MAX_LEN),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .LEN_W   (LEN_W)
  ) u_collision (
    .i_new_x (w_new_x),
    .i_new_y (w_new_y),
    .i_seg_x (w_flat_x),
    .i_seg_y (w_flat_y),
    .i_limit (w_limit),
    .o_hit   (w_hit)
  );

  assign w_collide = w_hit || w_wall;
  assign w_do_move = w_move_req && !w_collide;

  always_comb begin
    w_pend_sum = {1'b0, r_pending};
    if (w_do_move && (r_pending != '0)) w_pend_sum = w_pend_sum - (PEND_W+1)'(1);
    if (bus.grow) w_pend_sum = w_pend_sum + (PEND_W+1)'(GROW_STEP);
    w_pending_next = (w_pend_sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : w_pend_sum[PEND_W-1:0];
  end

  always_ff @(posedge screenClock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= '0;
        r_seg_y[i] <= '0;
      end
      r_seg_x[0] <= X_W'(START_X);
      r_seg_y[0] <= Y_W'(START_Y);
      r_length   <= LEN_W'(1);
      r_pending  <= '0;
      r_heading  <= DIR_NONE;
      r_state    <= ST_IDLE;
      r_running  <= 1'b0;
      r_dead     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_move_req) begin
            r_heading <= w_heading_next;
            if (w_collide) begin
              r_state   <= ST_DEAD;
              r_running <= 1'b0;
              r_dead    <= 1'b1;
            end else begin
              r_state    <= ST_RUN;
              r_running  <= 1'b1;
              r_length   <= w_length_next;
              r_seg_x[0] <= w_new_x;
              r_seg_y[0] <= w_new_y;
              for (int i = 1; i < MAX_LEN; i++) begin
                if (LEN_W'(i) < w_length_next) begin
                  r_seg_x[i] <= r_seg_x[i-1];
                  r_seg_y[i] <= r_seg_y[i-1];
                end
              end
            end
          end
        end
        ST_DEAD: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// tb/tb_snake_body_engine.sv - directed self-checking bench for snake_body_engine.
module tb_snake_body_engine;
  import snake_pkg::*;

  localparam int MAX_LEN = 128;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;

  logic screenClock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  snake_body_engine_if #(.MAX_LEN(MAX_LEN), .X_W(X_W), .Y_W(Y_W)) bus_if ();

  snake_body_engine dut (
    .screenClock (screenClock),
    .reset       (reset),
    .bus         (bus_if.slave)
  );

  always #5 screenClock = ~screenClock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int seg_x(input int i);
    return int'(bus_if.snake_x[i*X_W +: X_W]);
  endfunction

  function automatic int seg_y(input int i);
    return int'(bus_if.snake_y[i*Y_W +: Y_W]);
  endfunction

  task automatic step(input logic [3:0] d, input logic g);
    bus_if.dir  = d;
    bus_if.grow = g;
    @(posedge screenClock);
    #1;
    bus_if.grow = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #7;
    reset = 1'b0;
  endtask

  task automatic check_head(input string tag, input int x, input int y, input int len);
    check({tag, "_x"}, seg_x(0), x);
    check({tag, "_y"}, seg_y(0), y);
    check({tag, "_len"}, int'(bus_if.length), len);
  endtask

  initial begin
    reset       = 1'b1;
    bus_if.dir  = DIR_NONE;
    bus_if.grow = 1'b0;
    #12;
    reset = 1'b0;

    check_head("rst", 100, 160, 1);
    check("rst_seg1_x", seg_x(1), 0);
    check("rst_running", int'(bus_if.running), 0);
    check("rst_dead", int'(bus_if.dead), 0);

    step(DIR_NONE, 1'b0);
    step(4'b0101, 1'b0);
    check_head("idle_hold", 100, 160, 1);
    check("idle_running", int'(bus_if.running), 0);

    for (int k = 1; k <= 3; k++) begin
      step(DIR_RIGHT, 1'b0);
      check_head($sformatf("right%0d", k), 100 + 10*k, 160, 1);
      check($sformatf("right%0d_running", k), int'(bus_if.running), 1);
    end

    step(DIR_RIGHT, 1'b1);
    check_head("grow_a", 140, 160, 1);
    step(DIR_RIGHT, 1'b0);
    check_head("grow_b", 150, 160, 2);
    check("grow_b_seg1", seg_x(1), 140);
    step(DIR_RIGHT, 1'b0);
    check_head("grow_c", 160, 160, 3);
    check("grow_c_seg2", seg_x(2), 140);
    step(DIR_RIGHT, 1'b0);
    check_head("grow_d", 170, 160, 3);
    check("grow_d_seg1", seg_x(1), 160);

    step(DIR_LEFT, 1'b0);
    check_head("rev1", 180, 160, 3);
    step(DIR_LEFT, 1'b0);
    check_head("rev2", 190, 160, 3);
    check("rev2_seg1", seg_x(1), 180);

    step(DIR_RIGHT, 1'b1);
    step(DIR_RIGHT, 1'b0);
    check_head("grow4", 210, 160, 4);
    step(DIR_DOWN, 1'b0);
    check_head("down", 210, 170, 5);
    step(DIR_LEFT, 1'b0);
    check_head("left", 200, 170, 5);
    check("left_dead", int'(bus_if.dead), 0);
    step(DIR_UP, 1'b0);
    check("bite_dead", int'(bus_if.dead), 1);
    check("bite_running", int'(bus_if.running), 0);
    check_head("bite", 200, 170, 5);
    step(DIR_RIGHT, 1'b1);
    step(DIR_RIGHT, 1'b0);
    check_head("frozen", 200, 170, 5);
    check("frozen_seg1_x", seg_x(1), 210);
    check("frozen_seg1_y", seg_y(1), 170);
    check("frozen_seg4_x", seg_x(4), 190);
    check("frozen_seg4_y", seg_y(4), 160);
    check("frozen_dead", int'(bus_if.dead), 1);

    do_reset();
    for (int k = 1; k <= 16; k++) step(DIR_UP, 1'b0);
    check_head("up16", 100, 0, 1);
    check("up16_dead", int'(bus_if.dead), 0);
    step(DIR_UP, 1'b0);
`ifdef SNAKE_WRAP_EN
    check_head("up17_wrap", 100, 470, 1);
    check("up17_dead", int'(bus_if.dead), 0);
`else
    check_head("up17_wall", 100, 0, 1);
    check("up17_dead", int'(bus_if.dead), 1);
`endif

    do_reset();
    for (int k = 0; k < 50; k++) step(DIR_RIGHT, 1'b1);
    check_head("lap_r", 600, 160, 50);
    for (int k = 0; k < 25; k++) step(DIR_DOWN, 1'b1);
    check_head("lap_d", 600, 410, 75);
    for (int k = 0; k < 50; k++) step(DIR_LEFT, 1'b1);
    check_head("lap_l", 100, 410, 125);
    for (int k = 0; k < 25; k++) step(DIR_UP, 1'b1);
    check_head("lap_u", 100, 160, 128);
    check("lap_dead", int'(bus_if.dead), 0);
    check("lap_seg1_y", seg_y(1), 170);
    check("lap_tail_x", seg_x(127), 330);
    check("lap_tail_y", seg_y(127), 160);

    #2;
    reset = 1'b1;
    #1;
    check_head("midrst", 100, 160, 1);
    check("midrst_running", int'(bus_if.running), 0);
    check("midrst_seg1_x", seg_x(1), 0);
    check("midrst_seg1_y", seg_y(1), 0);
    #4;
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
